// File: rtl/swap_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : swap_pkg
//  Brief    : Shared operand width, pair type and swap helper for the swap stage.
//  Revision : 1.0 - initial release
// ============================================================================
package swap_pkg;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  // With sort_en the pair is exchanged only when a > b, giving (min,max).
  function automatic pair_t swap_pair(input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b,
                                      input logic             sort_en);
    pair_t r;
    if (sort_en && !(a > b)) begin
      r.a = a;
      r.b = b;
    end else begin
      r.a = b;
      r.b = a;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/swap_pair_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : swap_pair_stage_if
//  Brief    : Upstream/downstream handshake bundle of the swap pair stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface swap_pair_stage_if;
  import swap_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [CNT_W-1:0] pair_count;

  // Environment side: produces pairs and consumes results.
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_a, out_b, pair_count
  );

  // Stage side.
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_a, out_b, pair_count
  );

endinterface
`default_nettype wire

// File: rtl/swap_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : swap_fifo
//  Brief    : Synchronous pair_t FIFO, extra-MSB pointers for full/empty.
//  Revision : 1.0 - initial release
// ============================================================================
module swap_fifo
  import swap_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  wire logic  clk,
  input  wire logic  rst,
  input  wire logic  push_i,
  input  wire pair_t wdata_i,
  input  wire logic  pop_i,
  output pair_t      rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  pair_t         mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Callers gate push/pop; the full/empty guards here keep pointers sane regardless.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i && !full_o)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i  && !empty_o) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/swap_pair_stage.sv
`default_nettype none
// ============================================================================
//  Module   : swap_pair_stage
//  Brief    : Handshaked swap stage: (a,b) in, (b,a) out through a small FIFO.
//             Define SWAP_SORT_EN for compare-and-swap (min,max) ordering.
//  Revision : 1.0 - initial release
// ============================================================================
module swap_pair_stage
  import swap_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input wire logic         clk,
  input wire logic         rst,
  swap_pair_stage_if.slave sp_if
);

`ifdef SWAP_SORT_EN
  localparam logic SORT_EN = 1'b1;
`else
  localparam logic SORT_EN = 1'b0;
`endif

  pair_t            wr_pair;
  pair_t            head;
  pair_t            hold_q, hold_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty;
  logic             push, pop;
  logic             out_valid;

  assign wr_pair = swap_pair(sp_if.in_a, sp_if.in_b, SORT_EN);

  // Ready reflects FIFO occupancy only, so there is no combinational out->in path.
  assign sp_if.in_ready = !rst && !full;
  assign out_valid      = !rst && !empty;
  assign push           = sp_if.in_valid && sp_if.in_ready;
  assign pop            = out_valid && sp_if.out_ready;

  swap_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wr_pair),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Between transfers the data lines keep showing the last delivered pair.
  always_comb begin
    hold_d  = hold_q;
    count_d = count_q;
    if (pop) begin
      hold_d  = head;
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      count_q <= '0;
    end else begin
      hold_q  <= hold_d;
      count_q <= count_d;
    end
  end

  assign sp_if.out_valid  = out_valid;
  assign sp_if.out_a      = empty ? hold_q.a : head.a;
  assign sp_if.out_b      = empty ? hold_q.b : head.b;
  assign sp_if.pair_count = count_q;

endmodule
`default_nettype wire
